simulador_drone_param: RTL and testbench
========================================

Name: simulador_drone_param

Overview:
- Parametrised next-generation drone game core: grid size, tick periods per mode, life budget and obstacle seed are parameters.
- Adds three difficulty modes, a life-selection phase, LFSR-generated obstacles and a collision/lives mechanism.
- Sits between the debounced board inputs (iniciar, controle, confirma) and the display/debug outputs.
- Top-level game core of the drone project.

Parameters:
- POS_W, 4: position width; the grid is 2**POS_W columns by 2**POS_W rows.
- VIDAS_W, 3: width of the lives and collision counters.
- MAX_VIDAS, 7: upper limit of selectable lives; must be at most 2**VIDAS_W-1.
- TICK_FACIL, 2000: clocks per movement tick in easy mode.
- TICK_MEDIO, 1500: clocks per tick in medium mode.
- TICK_DIFICIL, 1000: clocks per tick in hard mode.
- LFSR_SEED, 8'hA5: obstacle LFSR seed; must be nonzero.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  level; starts or restarts a game
- controle  in  2  00 hold, 01 up/increment, 10 down/decrement, 11 treated as 00
- confirma  in  1  level; only the rising edge is used
- venceu  out  1  high while in VENCEU
- perdeu  out  1  high while in PERDEU
- db_posicao_horizontal  out  POS_W  current column
- db_posicao_vertical  out  POS_W  current row
- db_obstaculos  out  POS_W  obstacle row of the current column
- obstaculo_valido  out  1  current column holds an obstacle
- db_vidas  out  VIDAS_W  remaining lives
- colisao_counter_out  out  VIDAS_W  collisions this game, saturating
- db_estado  out  4  state code
- db_modo  out  2  00 facil, 01 medio, 10 dificil

Behaviour:
- Reset (async): state INICIAL; every output and register 0; LFSR = LFSR_SEED; edge-detector history = 0.
- Edge detectors:
  - confirma_edge = confirma & ~confirma_q.
  - ctrl_up_edge on the transition of controle into 01; ctrl_dn_edge on the transition into 10.
  - Holding an input produces exactly one event.
- State machine (db_estado code in brackets):
  - INICIAL [0]: iniciar=1 -> PREPARACAO.
  - PREPARACAO [1], one cycle: horizontal=0; vertical=2**(POS_W-1); vidas=1; colisoes=0; LFSR=seed; tick counter=0 -> ESCOLHE_MODO.
  - ESCOLHE_MODO [2]: on confirma_edge, latch modo from controle (11 -> 00) -> ESCOLHE_VIDAS.
  - ESCOLHE_VIDAS [3]:
    - ctrl_up_edge increments vidas, saturating at MAX_VIDAS.
    - ctrl_dn_edge decrements vidas, saturating at 1.
    - confirma_edge -> JOGANDO with tick counter=0.
  - JOGANDO [4]:
    - The tick counter counts up to TICK(modo)-1.
    - On the terminal count (the tick cycle):
      - counter returns to 0.
      - horizontal+1.
      - vertical moves by the controle level sampled that cycle; saturates at 0 and 2**POS_W-1.
      - LFSR advances once.
      - -> VERIFICA.
  - VERIFICA [5], one cycle, evaluated on the new position:
    - obstaculo_valido and vertical==db_obstaculos -> COLISAO.
    - else horizontal==2**POS_W-1 -> VENCEU.
    - else -> JOGANDO.
  - COLISAO [6], one cycle:
    - vidas-1; colisao_counter+1, saturating.
    - New vidas==0 -> PERDEU; else last column -> VENCEU; else -> JOGANDO.
  - VENCEU [7] / PERDEU [8]: outputs hold; iniciar=1 -> PREPARACAO.
- Obstacles:
  - LFSR is 8-bit Fibonacci, taps 8,6,5,4, shifting left.
  - db_obstaculos = LFSR[POS_W-1:0].
  - obstaculo_valido = 0 in column 0.
  - In facil, obstaculo_valido = 1 only in even columns.
  - In medio/dificil, obstaculo_valido = 1 in every column from 1 onward.
- Tick counter width: clog2 of the largest TICK.
- iniciar is ignored outside INICIAL, VENCEU and PERDEU.
- Reset mid-game: immediate return to INICIAL with all values cleared.
- Movement latency: a held controle level moves the drone at most one row per tick.

Decomposition:
- Package drone_pkg holds:
  - state codes (INICIAL..PERDEU);
  - mode codes MODO_FACIL/MEDIO/DIFICIL;
  - controle codes CTRL_HOLD/UP/DOWN;
  - LFSR tap constant.
- Sub-module drone_obstaculo_lfsr: clock, reset, load, seed, advance -> value[7:0].
- FSM, datapath and tick counter stay in simulador_drone_param.

Test Plan:
Bench parameters: TICK_FACIL=20, TICK_MEDIO=15, TICK_DIFICIL=10, POS_W=4.
- Reset then iniciar=1 for 2 cycles -> db_estado 0->1->2; vertical=8, horizontal=0, db_vidas=1.
- confirma held 10 cycles with controle=00 -> one mode latch (db_modo=00), state 3; controle 01,00,01,00 then confirma -> db_vidas=3, state 4.
- Hold controle=00 in facil -> horizontal increments every 20 clocks; vertical stays 8; with no collisions venceu=1 after 15 ticks.
- Force collisions with vertical tracking db_obstaculos, vidas=3 -> colisao_counter_out 1,2,3; db_vidas reaches 0; perdeu=1, state 8.
- Hold controle=10 for 20 ticks -> vertical saturates at 0, no wrap; controle=01 saturates at 15.
- Assert reset during JOGANDO -> next cycle state 0, all outputs 0; iniciar in PERDEU -> PREPARACAO and a fresh game.

Source files
------------

// File: rtl/drone_pkg.sv
// Shared definitions for the drone game core.
// Holds state codes, difficulty mode codes, controle codes and the obstacle
// LFSR tap mask with its feedback helper.
package drone_pkg;

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      PREPARACAO    = 4'd1,
      ESCOLHE_MODO  = 4'd2,
      ESCOLHE_VIDAS = 4'd3,
      JOGANDO       = 4'd4,
      VERIFICA      = 4'd5,
      COLISAO       = 4'd6,
      VENCEU        = 4'd7,
      PERDEU        = 4'd8
   } estado_t;

   localparam logic [1:0] MODO_FACIL   = 2'b00;
   localparam logic [1:0] MODO_MEDIO   = 2'b01;
   localparam logic [1:0] MODO_DIFICIL = 2'b10;

   localparam logic [1:0] CTRL_HOLD = 2'b00;
   localparam logic [1:0] CTRL_UP   = 2'b01;
   localparam logic [1:0] CTRL_DOWN = 2'b10;

   // Taps 8,6,5,4 (1-based) map to bits 7,5,4,3.
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic lfsr_fb(input logic [7:0] v);
      return ^(v & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/drone_obstaculo_lfsr.sv
// Obstacle generator: 8-bit Fibonacci LFSR shifting left.
// Ports: clock, reset (async, high), load (reload seed), seed, advance (one
// step), value (current register contents). load has priority over advance.
module drone_obstaculo_lfsr
   import drone_pkg::*;
#(
   parameter logic [7:0] SEED_RST = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] value
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value <= SEED_RST;
      end else if (load) begin
         value <= seed;
      end else if (advance) begin
         value <= {value[6:0], lfsr_fb(value)};
      end
   end

endmodule

// File: rtl/simulador_drone_param.sv
// Drone game core: mode and lives selection, timed movement across the grid,
// LFSR obstacles and collision/lives handling.
// Ports: clock, reset (async, high); inputs iniciar, controle[1:0], confirma;
// outputs venceu, perdeu, position/obstacle/lives/collision/state/mode debug.
module simulador_drone_param
   import drone_pkg::*;
#(
   parameter int         POS_W        = 4,
   parameter int         VIDAS_W      = 3,
   parameter int         MAX_VIDAS    = 7,
   parameter int         TICK_FACIL   = 2000,
   parameter int         TICK_MEDIO   = 1500,
   parameter int         TICK_DIFICIL = 1000,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic [1:0]         controle,
   input  logic               confirma,
   output logic               venceu,
   output logic               perdeu,
   output logic [POS_W-1:0]   db_posicao_horizontal,
   output logic [POS_W-1:0]   db_posicao_vertical,
   output logic [POS_W-1:0]   db_obstaculos,
   output logic               obstaculo_valido,
   output logic [VIDAS_W-1:0] db_vidas,
   output logic [VIDAS_W-1:0] colisao_counter_out,
   output logic [3:0]         db_estado,
   output logic [1:0]         db_modo
);

   localparam int TICK_MAX_AB = (TICK_FACIL > TICK_MEDIO) ? TICK_FACIL : TICK_MEDIO;
   localparam int TICK_MAX    = (TICK_MAX_AB > TICK_DIFICIL) ? TICK_MAX_AB : TICK_DIFICIL;
   localparam int CNT_W       = $clog2(TICK_MAX);

   localparam logic [POS_W-1:0]   POS_MAX   = {POS_W{1'b1}};
   localparam logic [POS_W-1:0]   V_INICIAL = POS_W'(1 << (POS_W - 1));
   localparam logic [VIDAS_W-1:0] VIDAS_MAX = VIDAS_W'(MAX_VIDAS);
   localparam logic [VIDAS_W-1:0] UMA_VIDA  = VIDAS_W'(1);

   estado_t              estado;
   logic [POS_W-1:0]     horiz;
   logic [POS_W-1:0]     vert;
   logic [VIDAS_W-1:0]   vidas;
   logic [VIDAS_W-1:0]   colisoes;
   logic [1:0]           modo;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     tick_ult;
   logic                 confirma_q;
   logic [1:0]           controle_q;
   logic [7:0]           lfsr_val;
   logic                 unused_lfsr;

   logic confirma_edge, ctrl_up_edge, ctrl_dn_edge, cnt_fim, tick, colide;

   assign confirma_edge = confirma & ~confirma_q;
   assign ctrl_up_edge  = (controle == CTRL_UP)   && (controle_q != CTRL_UP);
   assign ctrl_dn_edge  = (controle == CTRL_DOWN) && (controle_q != CTRL_DOWN);

   always_comb begin
      tick_ult = CNT_W'(TICK_FACIL - 1);
      case (modo)
         MODO_MEDIO:   tick_ult = CNT_W'(TICK_MEDIO - 1);
         MODO_DIFICIL: tick_ult = CNT_W'(TICK_DIFICIL - 1);
         default:      tick_ult = CNT_W'(TICK_FACIL - 1);
      endcase
   end

   assign cnt_fim = (cnt == tick_ult);
   assign tick    = (estado == JOGANDO) && cnt_fim;

   // Column 0 is always free; easy mode only places obstacles on even columns.
   assign obstaculo_valido = (horiz != '0) && ((modo != MODO_FACIL) || !horiz[0]);
   assign colide           = obstaculo_valido && (vert == lfsr_val[POS_W-1:0]);

   drone_obstaculo_lfsr #(.SEED_RST(LFSR_SEED)) u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .load    (estado == PREPARACAO),
      .seed    (LFSR_SEED),
      .advance (tick),
      .value   (lfsr_val)
   );

   assign unused_lfsr = ^lfsr_val[7:POS_W];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= INICIAL;
         horiz      <= '0;
         vert       <= '0;
         vidas      <= '0;
         colisoes   <= '0;
         modo       <= MODO_FACIL;
         cnt        <= '0;
         confirma_q <= 1'b0;
         controle_q <= CTRL_HOLD;
      end else begin
         confirma_q <= confirma;
         controle_q <= controle;

         // The counter keeps running through VERIFICA/COLISAO so the tick
         // period stays exactly TICK(modo) clocks regardless of those cycles.
         if (estado == JOGANDO || estado == VERIFICA || estado == COLISAO) begin
            cnt <= cnt_fim ? '0 : cnt + 1'b1;
         end

         case (estado)
            INICIAL: begin
               if (iniciar) estado <= PREPARACAO;
            end
            PREPARACAO: begin
               horiz    <= '0;
               vert     <= V_INICIAL;
               vidas    <= UMA_VIDA;
               colisoes <= '0;
               cnt      <= '0;
               estado   <= ESCOLHE_MODO;
            end
            ESCOLHE_MODO: begin
               if (confirma_edge) begin
                  modo   <= (controle == 2'b11) ? MODO_FACIL : controle;
                  estado <= ESCOLHE_VIDAS;
               end
            end
            ESCOLHE_VIDAS: begin
               if (ctrl_up_edge && vidas < VIDAS_MAX) vidas <= vidas + 1'b1;
               if (ctrl_dn_edge && vidas > UMA_VIDA)  vidas <= vidas - 1'b1;
               if (confirma_edge) begin
                  cnt    <= '0;
                  estado <= JOGANDO;
               end
            end
            JOGANDO: begin
               if (cnt_fim) begin
                  horiz <= horiz + 1'b1;
                  case (controle)
                     CTRL_UP:   if (vert != POS_MAX) vert <= vert + 1'b1;
                     CTRL_DOWN: if (vert != '0)      vert <= vert - 1'b1;
                     default:   vert <= vert;
                  endcase
                  estado <= VERIFICA;
               end
            end
            VERIFICA: begin
               if (colide)                estado <= COLISAO;
               else if (horiz == POS_MAX) estado <= VENCEU;
               else                       estado <= JOGANDO;
            end
            COLISAO: begin
               vidas <= vidas - 1'b1;
               if (colisoes != {VIDAS_W{1'b1}}) colisoes <= colisoes + 1'b1;
               if (vidas == UMA_VIDA)     estado <= PERDEU;
               else if (horiz == POS_MAX) estado <= VENCEU;
               else                       estado <= JOGANDO;
            end
            VENCEU, PERDEU: begin
               if (iniciar) estado <= PREPARACAO;
            end
            default: estado <= INICIAL;
         endcase
      end
   end

   assign venceu                = (estado == VENCEU);
   assign perdeu                = (estado == PERDEU);
   assign db_posicao_horizontal = horiz;
   assign db_posicao_vertical   = vert;
   // Obstacle row is blanked while idle so the display reads all zeros.
   assign db_obstaculos         = (estado == INICIAL) ? '0 : lfsr_val[POS_W-1:0];
   assign db_vidas              = vidas;
   assign colisao_counter_out   = colisoes;
   assign db_estado             = estado;
   assign db_modo               = modo;

endmodule

// File: tb/tb_simulador_drone_param.sv
// Directed bench for simulador_drone_param with short tick periods.
// Plays four games: easy straight run, medium collision run to PERDEU,
// hard downward run with saturation, medium upward run interrupted by reset.
module tb_simulador_drone_param;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic [1:0] controle;
   logic       confirma;
   logic       venceu, perdeu, obstaculo_valido;
   logic [3:0] db_posicao_horizontal, db_posicao_vertical, db_obstaculos;
   logic [2:0] db_vidas, colisao_counter_out;
   logic [3:0] db_estado;
   logic [1:0] db_modo;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;
   int modo_cur = 0;

   // Low nibble of the LFSR after k advances from seed 8'hA5 (index = column).
   int obst_tbl [16];
   // Medium game: controle per tick and expected row afterwards.
   int g2_c [14];
   int g2_v [14];

   simulador_drone_param #(
      .POS_W(4), .VIDAS_W(3), .MAX_VIDAS(7),
      .TICK_FACIL(20), .TICK_MEDIO(15), .TICK_DIFICIL(10),
      .LFSR_SEED(8'hA5)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .controle(controle),
      .confirma(confirma), .venceu(venceu), .perdeu(perdeu),
      .db_posicao_horizontal(db_posicao_horizontal),
      .db_posicao_vertical(db_posicao_vertical),
      .db_obstaculos(db_obstaculos), .obstaculo_valido(obstaculo_valido),
      .db_vidas(db_vidas), .colisao_counter_out(colisao_counter_out),
      .db_estado(db_estado), .db_modo(db_modo)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         cyc++;
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_estado"}, db_estado, 0);
      check_val({tag, "_horiz"}, db_posicao_horizontal, 0);
      check_val({tag, "_vert"}, db_posicao_vertical, 0);
      check_val({tag, "_obst"}, db_obstaculos, 0);
      check_val({tag, "_valido"}, obstaculo_valido, 0);
      check_val({tag, "_vidas"}, db_vidas, 0);
      check_val({tag, "_colis"}, colisao_counter_out, 0);
      check_val({tag, "_venceu"}, venceu, 0);
      check_val({tag, "_perdeu"}, perdeu, 0);
      check_val({tag, "_modo"}, db_modo, 0);
   endtask

   // Start a game from INICIAL/VENCEU/PERDEU, pick mode m and nv lives,
   // exercising both lives saturation limits on the way.
   task automatic setup(input logic [1:0] m, input int nv);
      iniciar = 1'b1;
      step(1);
      check_val("prep_estado", db_estado, 1);
      step(1);
      iniciar = 1'b0;
      check_val("modo_estado", db_estado, 2);
      check_val("prep_vert", db_posicao_vertical, 8);
      check_val("prep_horiz", db_posicao_horizontal, 0);
      check_val("prep_vidas", db_vidas, 1);
      check_val("prep_colis", colisao_counter_out, 0);
      controle = m;
      confirma = 1'b1;
      step(10);
      modo_cur = (m == 2'b11) ? 0 : int'(m);
      check_val("vidas_estado", db_estado, 3);
      check_val("modo_latch", db_modo, modo_cur);
      confirma = 1'b0;
      controle = 2'b00;
      step(1);
      controle = 2'b10; step(1); controle = 2'b00; step(1);
      check_val("vidas_floor", db_vidas, 1);
      repeat (8) begin
         controle = 2'b01; step(1); controle = 2'b00; step(1);
      end
      check_val("vidas_ceil", db_vidas, 7);
      repeat (7 - nv) begin
         controle = 2'b10; step(1); controle = 2'b00; step(1);
      end
      check_val("vidas_sel", db_vidas, nv);
      confirma = 1'b1;
      step(1);
      check_val("jogando_estado", db_estado, 4);
      last_cyc = cyc;
      confirma = 1'b0;
   endtask

   // Wait (bounded) for column k, check period, obstacle and the outcome
   // two cycles later (after VERIFICA and a possible COLISAO).
   task automatic run_tick(input logic [1:0] ctl, input int k, input int per,
                           input int ev, input int ec, input int evd);
      int n;
      n = 0;
      controle = ctl;
      while (db_posicao_horizontal != k && n < 60) begin
         step(1);
         n++;
      end
      check_val($sformatf("horiz_k%0d", k), db_posicao_horizontal, k);
      check_val($sformatf("gap_k%0d", k), cyc - last_cyc, per);
      last_cyc = cyc;
      check_val($sformatf("obst_k%0d", k), db_obstaculos, obst_tbl[k]);
      check_val($sformatf("valido_k%0d", k), obstaculo_valido,
                (modo_cur != 0 || (k % 2) == 0) ? 1 : 0);
      step(2);
      check_val($sformatf("vert_k%0d", k), db_posicao_vertical, ev);
      check_val($sformatf("colis_k%0d", k), colisao_counter_out, ec);
      check_val($sformatf("vidas_k%0d", k), db_vidas, evd);
   endtask

   initial begin
      obst_tbl = '{5, 10, 5, 10, 4, 9, 3, 7, 14, 13, 11, 7, 14, 13, 11, 6};
      g2_c     = '{1, 2, 1, 2, 1, 2, 2, 1, 1, 1, 2, 1, 1, 0};
      g2_v     = '{9, 8, 9, 8, 9, 8, 7, 8, 9, 10, 9, 10, 11, 11};

      reset = 1'b1; iniciar = 1'b0; confirma = 1'b0; controle = 2'b00;
      step(2);
      check_zero("rst");
      reset = 1'b0;
      step(2);
      check_val("idle_estado", db_estado, 0);

      // Game 1: easy (controle 11 at confirm maps to easy), 3 lives, hold
      // row 8 with alternating 00/11 levels; no obstacle at row 8.
      setup(2'b11, 3);
      for (int k = 1; k <= 15; k++)
         run_tick((k % 2) ? 2'b11 : 2'b00, k, 20, 8, 0, 3);
      check_val("g1_venceu", venceu, 1);
      check_val("g1_estado", db_estado, 7);
      step(5);
      check_val("g1_hold", db_estado, 7);
      check_val("g1_hold_h", db_posicao_horizontal, 15);

      // Game 2: medium, 3 lives, steer onto obstacles at columns 5, 7, 14.
      setup(2'b01, 3);
      for (int k = 1; k <= 14; k++) begin
         int ec;
         ec = (k >= 14) ? 3 : (k >= 7) ? 2 : (k >= 5) ? 1 : 0;
         run_tick(2'(g2_c[k-1]), k, 15, g2_v[k-1], ec, 3 - ec);
      end
      check_val("g2_perdeu", perdeu, 1);
      check_val("g2_venceu", venceu, 0);
      check_val("g2_estado", db_estado, 8);
      step(5);
      check_val("g2_hold", db_estado, 8);

      // Game 3: hard, 2 lives, hold down: one hit at column 4, floor at 0.
      setup(2'b10, 2);
      for (int k = 1; k <= 15; k++)
         run_tick(2'b10, k, 10, (k < 8) ? 8 - k : 0,
                  (k >= 4) ? 1 : 0, (k >= 4) ? 1 : 2);
      check_val("g3_venceu", venceu, 1);
      check_val("g3_estado", db_estado, 7);

      // Game 4: medium, 1 life, hold up to the ceiling, then reset mid-play.
      setup(2'b01, 1);
      for (int k = 1; k <= 10; k++)
         run_tick(2'b01, k, 15, (k < 7) ? 8 + k : 15, 0, 1);
      check_val("g4_estado", db_estado, 4);
      reset = 1'b1;
      step(1);
      check_zero("midrst");
      reset = 1'b0;
      controle = 2'b00;
      step(2);
      check_val("after_rst_estado", db_estado, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
